// File: rtl/prf_dealloc_buffer.sv
// ----------------------------------------------------------------------------
// prf_dealloc_buffer
//   Writer-side companion of the banked free list. Up to DEALLOC_WIDTH freed
//   physical registers arrive per cycle from ROB commit. Each one is steered to
//   the bank selected by its low LOG_PRF_BANK_COUNT bits and queued in that
//   bank's FIFO. Each bank drains one PR per cycle into the free list under
//   valid/ready, so bursts that all target one bank are absorbed.
//
// Ports
//   CLK                   in   clock, all state on posedge
//   nRST                  in   synchronous active-low reset
//   dealloc_valid_by_way  in   way carries a freed PR
//   dealloc_PR_by_way     in   freed PR per way
//   dealloc_ready         out  whole group is accepted this cycle when high
//   fl_enq_valid_by_bank  out  bank FIFO head valid
//   fl_enq_PR_by_bank     out  head PR with the bank bits dropped
//   fl_enq_ready_by_bank  in   free list bank accepts the head
//
// Configuration
//   PRF_DEALLOC_BUF_BYPASS_EN  when defined, the lowest accepted way that
//   targets an empty bank drives that bank's output in the same cycle and is
//   only written to the FIFO if the free list does not take it. When
//   undefined, outputs come purely from registered state.
// ----------------------------------------------------------------------------
module prf_dealloc_buffer #(
    parameter int PR_COUNT        = 128,
    parameter int PRF_BANK_COUNT  = 4,
    parameter int DEALLOC_WIDTH   = 4,
    parameter int BANK_FIFO_DEPTH = 8,
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic [DEALLOC_WIDTH-1:0]                         dealloc_valid_by_way,
    input  logic [DEALLOC_WIDTH-1:0][LOG_PR_COUNT-1:0]       dealloc_PR_by_way,
    output logic                                             dealloc_ready,
    output logic [PRF_BANK_COUNT-1:0]                        fl_enq_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] fl_enq_PR_by_bank,
    input  logic [PRF_BANK_COUNT-1:0]                        fl_enq_ready_by_bank
);

    localparam int CNT_W = $clog2(BANK_FIFO_DEPTH + 1);
    localparam int PTR_W = (BANK_FIFO_DEPTH > 1) ? $clog2(BANK_FIFO_DEPTH) : 1;
    localparam int UPW   = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
    localparam int OFS_W = $clog2(DEALLOC_WIDTH + 1);

    logic [UPW-1:0]   mem_q    [PRF_BANK_COUNT][BANK_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [PRF_BANK_COUNT];
    logic [PTR_W-1:0] wr_ptr_d [PRF_BANK_COUNT];
    logic [PTR_W-1:0] rd_ptr_q [PRF_BANK_COUNT];
    logic [PTR_W-1:0] rd_ptr_d [PRF_BANK_COUNT];
    logic [CNT_W-1:0] cnt_q    [PRF_BANK_COUNT];
    logic [CNT_W-1:0] cnt_d    [PRF_BANK_COUNT];

    logic [DEALLOC_WIDTH-1:0]          way_we;
    logic [LOG_PRF_BANK_COUNT-1:0]     way_bank [DEALLOC_WIDTH];
    logic [PTR_W-1:0]                  way_slot [DEALLOC_WIDTH];
    logic [UPW-1:0]                    way_up   [DEALLOC_WIDTH];
    logic [OFS_W-1:0]                  n_enq    [PRF_BANK_COUNT];
    logic [PRF_BANK_COUNT-1:0]         deq;

`ifdef PRF_DEALLOC_BUF_BYPASS_EN
    logic [PRF_BANK_COUNT-1:0]         byp_valid;
    logic [UPW-1:0]                    byp_pr [PRF_BANK_COUNT];
`endif

    // Offsets never exceed DEPTH, so one conditional subtract implements
    // the modulo for any depth, power of two or not.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned inc);
        int unsigned s;
        s = 32'(p) + inc;
        if (s >= BANK_FIFO_DEPTH) s = s - BANK_FIFO_DEPTH;
        return PTR_W'(s);
    endfunction

    // Headroom of DEALLOC_WIDTH in every bank guarantees a whole group fits.
    always_comb begin
        dealloc_ready = 1'b1;
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            if (cnt_q[b] > CNT_W'(BANK_FIFO_DEPTH - DEALLOC_WIDTH)) dealloc_ready = 1'b0;
        end
    end

    // Steering: walk ways lowest first so same-bank ways land in order.
    always_comb begin
        way_we = '0;
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) n_enq[b] = '0;
`ifdef PRF_DEALLOC_BUF_BYPASS_EN
        byp_valid = '0;
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) byp_pr[b] = '0;
`endif
        for (int unsigned w = 0; w < DEALLOC_WIDTH; w++) begin
            way_bank[w] = dealloc_PR_by_way[w][LOG_PRF_BANK_COUNT-1:0];
            way_up[w]   = dealloc_PR_by_way[w][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
            way_slot[w] = '0;
            if (dealloc_ready && dealloc_valid_by_way[w]) begin
                way_we[w] = 1'b1;
`ifdef PRF_DEALLOC_BUF_BYPASS_EN
                if (cnt_q[way_bank[w]] == '0 && !byp_valid[way_bank[w]]) begin
                    byp_valid[way_bank[w]] = 1'b1;
                    byp_pr[way_bank[w]]    = way_up[w];
                    if (fl_enq_ready_by_bank[way_bank[w]]) way_we[w] = 1'b0;
                end
`endif
                if (way_we[w]) begin
                    way_slot[w] = ptr_add(wr_ptr_q[way_bank[w]], 32'(n_enq[way_bank[w]]));
                    n_enq[way_bank[w]] = n_enq[way_bank[w]] + OFS_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            deq[b]      = (cnt_q[b] != '0) && fl_enq_ready_by_bank[b];
            rd_ptr_d[b] = deq[b] ? ptr_add(rd_ptr_q[b], 1) : rd_ptr_q[b];
            wr_ptr_d[b] = ptr_add(wr_ptr_q[b], 32'(n_enq[b]));
            cnt_d[b]    = cnt_q[b] + CNT_W'(n_enq[b]) - CNT_W'(deq[b]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
                wr_ptr_q[b] <= '0;
                rd_ptr_q[b] <= '0;
                cnt_q[b]    <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
                wr_ptr_q[b] <= wr_ptr_d[b];
                rd_ptr_q[b] <= rd_ptr_d[b];
                cnt_q[b]    <= cnt_d[b];
            end
        end
    end

    // Entry storage is not reset; contents are don't-care while count is 0.
    always_ff @(posedge CLK) begin
        for (int unsigned w = 0; w < DEALLOC_WIDTH; w++) begin
            if (way_we[w]) mem_q[way_bank[w]][way_slot[w]] <= way_up[w];
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            fl_enq_valid_by_bank[b] = (cnt_q[b] != '0);
            fl_enq_PR_by_bank[b]    = mem_q[b][rd_ptr_q[b]];
`ifdef PRF_DEALLOC_BUF_BYPASS_EN
            if (byp_valid[b]) begin
                fl_enq_valid_by_bank[b] = 1'b1;
                fl_enq_PR_by_bank[b]    = byp_pr[b];
            end
`endif
        end
    end

endmodule

// File: tb/tb_prf_dealloc_buffer.sv
// ----------------------------------------------------------------------------
// tb_prf_dealloc_buffer
//   Drives directed and random dealloc groups into prf_dealloc_buffer and
//   checks per-bank output order, head values, valid flags and dealloc_ready
//   against a queue-based model of the per-bank FIFOs.
// ----------------------------------------------------------------------------
module tb_prf_dealloc_buffer;

    localparam int PRC   = 128;
    localparam int NB    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int LPR   = 7;
    localparam int UPW   = 5;

    logic CLK = 1'b0;
    logic nRST;
    logic [DW-1:0]           dv;
    logic [DW-1:0][LPR-1:0]  dpr;
    logic                    dready;
    logic [NB-1:0]           fv;
    logic [NB-1:0][UPW-1:0]  fpr;
    logic [NB-1:0]           fr;

    always #5 CLK = ~CLK;

    prf_dealloc_buffer #(
        .PR_COUNT(PRC),
        .PRF_BANK_COUNT(NB),
        .DEALLOC_WIDTH(DW),
        .BANK_FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .dealloc_valid_by_way(dv),
        .dealloc_PR_by_way(dpr),
        .dealloc_ready(dready),
        .fl_enq_valid_by_bank(fv),
        .fl_enq_PR_by_bank(fpr),
        .fl_enq_ready_by_bank(fr)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned groups_accepted = 0;
    bit          mon_en = 0;
    bit          fr_mode = 0;   // 1: randomize fl_enq_ready every cycle

    // Expected contents of each bank FIFO (upper PR bits), head at index 0.
    logic [UPW-1:0] q [NB][$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        bit r = 1'b1;
        for (int b = 0; b < NB; b++) if (q[b].size() > DEPTH - DW) r = 1'b0;
        return r;
    endfunction

    // Reference model: ready from occupancy before the edge, pops on
    // handshake, whole group pushed in way order when accepted.
    always @(posedge CLK) begin : model
        bit rdy;
        if (!nRST) begin
            for (int b = 0; b < NB; b++) q[b].delete();
        end else begin
            rdy = model_ready();
            for (int b = 0; b < NB; b++)
                if (q[b].size() != 0 && fr[b]) void'(q[b].pop_front());
            if (rdy) begin
                if (dv != '0) groups_accepted++;
                for (int w = 0; w < DW; w++)
                    if (dv[w]) q[int'(dpr[w]) % NB].push_back(UPW'(int'(dpr[w]) / NB));
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the model.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("dealloc_ready", 32'(dready), 32'(model_ready()));
            for (int b = 0; b < NB; b++) begin
                check($sformatf("valid_b%0d", b), 32'(fv[b]), 32'(q[b].size() != 0));
                if (q[b].size() != 0 && fv[b])
                    check($sformatf("head_b%0d", b), 32'(fpr[b]), 32'(q[b][0]));
            end
        end
    end

    task automatic step_fr();
        if (fr_mode) fr = NB'($urandom);
    endtask

    // Hold the group until the DUT takes it, as upstream would.
    task automatic send(input logic [DW-1:0] v, input logic [DW-1:0][LPR-1:0] p);
        bit acc;
        int unsigned waited = 0;
        dv  = v;
        dpr = p;
        step_fr();
        forever begin
            acc = dready;
            @(negedge CLK); #1;
            if (acc) break;
            waited++;
            step_fr();
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout actual=none expected=acceptance t=%0t", $time);
                break;
            end
        end
        dv = '0;
    endtask

    task automatic idle(input int unsigned n);
        dv = '0;
        for (int unsigned i = 0; i < n; i++) begin
            step_fr();
            @(negedge CLK); #1;
        end
    endtask

    initial begin
        logic [DW-1:0][LPR-1:0] p;
        logic [DW-1:0]          m;
        int unsigned            sent, g0;

        nRST = 1'b0;
        dv   = '1;
        for (int w = 0; w < DW; w++) dpr[w] = LPR'($urandom);
        fr   = '0;
        @(posedge CLK);
        mon_en = 1;
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        nRST = 1'b1;
        dv   = '0;
        idle(2);

        // Spread across all four banks, free list always ready.
        fr = '1;
        p[0] = 7'd4; p[1] = 7'd9; p[2] = 7'd14; p[3] = 7'd19;
        send(4'hF, p);
        idle(3);

        // Collision: everything to bank 0 with the free list stalled.
        fr = '0;
        p[0] = 7'd8;  p[1] = 7'd12; p[2] = 7'd16; p[3] = 7'd20;
        send(4'hF, p);
        p[0] = 7'd24; p[1] = 7'd28; p[2] = 7'd32; p[3] = 7'd36;
        send(4'hF, p);
        idle(1);

        // Backpressure hold: group held for 5 cycles before bank 0 drains.
        g0 = groups_accepted;
        p[0] = 7'd40; p[1] = 7'd44; p[2] = 7'd48; p[3] = 7'd52;
        fork
            send(4'hF, p);
            begin
                repeat (5) @(negedge CLK);
                #2 fr[0] = 1'b1;
            end
        join
        check("hold_single_accept", groups_accepted - g0, 1);
        fr = '1;
        idle(16);

        // Wrap: 20 PRs to bank 1 with sporadic ready.
        fr_mode = 1;
        sent = 0;
        while (sent < 20) begin
            m = '0;
            for (int w = 0; w < DW; w++) begin
                p[w] = LPR'(4 * $urandom_range(0, 31) + 1);
                if (sent < 20 && $urandom_range(0, 3) != 0) begin
                    m[w] = 1'b1;
                    sent++;
                end
            end
            if (m != '0) send(m, p);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        fr_mode = 0; fr = '1;
        idle(24);

        // Random mixed traffic.
        fr_mode = 1;
        for (int i = 0; i < 150; i++) begin
            for (int w = 0; w < DW; w++) p[w] = LPR'($urandom);
            send(DW'($urandom), p);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 4));
        end

        // Reset in the middle of a backed-up burst discards everything.
        fr_mode = 0; fr = '0;
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < DW; w++) p[w] = LPR'($urandom);
            send(4'hF, p);
        end
        nRST = 1'b0;
        @(negedge CLK); #1;
        nRST = 1'b1;
        fr = '1;
        idle(3);

        // Final drain with some fresh traffic after the reset.
        fr_mode = 1;
        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < DW; w++) p[w] = LPR'($urandom);
            send(DW'($urandom), p);
        end
        fr_mode = 0; fr = '1;
        idle(20);
        check("drained_valid", 32'(fv), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
